// File: rtl/seq_mul_unit_if.sv
// seq_mul_unit_if: request/response bundle for the sequential multiplier.
//   Requester side (master) drives iStart, iSigned, iFlush, iData_A, iData_B.
//   Multiplier side (slave) drives oBusy, oDone, oProduct, oResultLow, oOverflow.
interface seq_mul_unit_if #(
    parameter int WIDTH = 16
);
    logic               iStart;
    logic               iSigned;
    logic               iFlush;
    logic [WIDTH-1:0]   iData_A;
    logic [WIDTH-1:0]   iData_B;
    logic               oBusy;
    logic               oDone;
    logic [2*WIDTH-1:0] oProduct;
    logic [WIDTH-1:0]   oResultLow;
    logic               oOverflow;

    modport master (
        output iStart, iSigned, iFlush, iData_A, iData_B,
        input  oBusy, oDone, oProduct, oResultLow, oOverflow
    );

    modport slave (
        input  iStart, iSigned, iFlush, iData_A, iData_B,
        output oBusy, oDone, oProduct, oResultLow, oOverflow
    );
endinterface

// File: rtl/seq_mul_unit.sv
// seq_mul_unit: multi-cycle radix-2 shift-add multiplier, signed or unsigned
// per operation, with a start/busy/done handshake.
//   Clock : rising-edge system clock
//   Reset : asynchronous active-low reset
//   bus   : seq_mul_unit_if.slave
//           iStart/iSigned/iData_A/iData_B sampled when accepted (oBusy=0)
//           iFlush aborts to IDLE (beats iStart)
//           oBusy, oDone (1-cycle pulse), oProduct (2*WIDTH), oResultLow,
//           oOverflow (product does not fit in WIDTH bits)
module seq_mul_unit #(
    parameter int WIDTH      = 16,
    parameter bit EARLY_ZERO = 1'b1
) (
    input  logic          Clock,
    input  logic          Reset,
    seq_mul_unit_if.slave bus
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_SIGN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  mcand_q, mcand_d;   // |A|
    logic [PW-1:0]     acc_q,   acc_d;     // {partial sum, remaining multiplier bits}
    logic [CW-1:0]     cnt_q,   cnt_d;
    logic              neg_q,   neg_d;
    logic              sgn_q,   sgn_d;
    logic [PW-1:0]     prod_q,  prod_d;
    logic              ovf_q,   ovf_d;

    logic [WIDTH-1:0]  mag_a, mag_b;
    logic [WIDTH:0]    sum;
    logic [PW-1:0]     fin;
    logic              fin_ovf;

    // Magnitudes: the most-negative value maps onto itself, which is the
    // correct unsigned magnitude 2^(WIDTH-1).
    always_comb begin
        mag_a = (bus.iSigned && bus.iData_A[WIDTH-1]) ? -bus.iData_A : bus.iData_A;
        mag_b = (bus.iSigned && bus.iData_B[WIDTH-1]) ? -bus.iData_B : bus.iData_B;
    end

    // One radix-2 step; the extra bit keeps the carry that the shift pulls in.
    always_comb begin
        sum = {1'b0, acc_q[PW-1:WIDTH]} + {1'b0, (acc_q[0] ? mcand_q : '0)};
    end

    always_comb begin
        fin = neg_q ? -acc_q : acc_q;
        if (sgn_q)
            fin_ovf = (fin[PW-1:WIDTH] != {WIDTH{fin[WIDTH-1]}});
        else
            fin_ovf = (fin[PW-1:WIDTH] != '0);
    end

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        sgn_d   = sgn_q;
        prod_d  = prod_q;
        ovf_d   = ovf_q;

        if (bus.iFlush) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.iStart) begin
                        mcand_d = mag_a;
                        acc_d   = {{WIDTH{1'b0}}, mag_b};
                        cnt_d   = '0;
                        sgn_d   = bus.iSigned;
                        neg_d   = bus.iSigned & (bus.iData_A[WIDTH-1] ^ bus.iData_B[WIDTH-1]);
                        if (EARLY_ZERO && (bus.iData_A == '0 || bus.iData_B == '0)) begin
                            prod_d  = '0;
                            ovf_d   = 1'b0;
                            state_d = S_DONE;
                        end else begin
                            state_d = S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    acc_d = {sum, acc_q[WIDTH-1:1]};
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1))
                        state_d = S_SIGN;
                end
                S_SIGN: begin
                    prod_d  = fin;
                    ovf_d   = fin_ovf;
                    state_d = S_DONE;
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            mcand_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            sgn_q   <= 1'b0;
            prod_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            sgn_q   <= sgn_d;
            prod_q  <= prod_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.oBusy      = (state_q != S_IDLE);
    assign bus.oDone      = (state_q == S_DONE);
    assign bus.oProduct   = prod_q;
    assign bus.oResultLow = prod_q[WIDTH-1:0];
    assign bus.oOverflow  = ovf_q;
endmodule

// File: tb/tb_seq_mul_unit.sv
module tb_seq_mul_unit;
    logic Clock = 1'b0;
    logic Reset = 1'b0;
    always #5 Clock = ~Clock;

    seq_mul_unit_if #(.WIDTH(16)) bus ();
    seq_mul_unit_if #(.WIDTH(16)) bus0 ();

    seq_mul_unit #(.WIDTH(16), .EARLY_ZERO(1'b1)) u_dut (
        .Clock(Clock), .Reset(Reset), .bus(bus)
    );
    seq_mul_unit #(.WIDTH(16), .EARLY_ZERO(1'b0)) u_dut0 (
        .Clock(Clock), .Reset(Reset), .bus(bus0)
    );

    int total = 0;
    int bad   = 0;

    // sel=1 routes stimulus/observation to the EARLY_ZERO=0 instance
    bit          sel = 1'b0;
    logic        busy_s, done_s, ovf_s;
    logic [31:0] prod_s;
    logic [15:0] low_s;

    always_comb begin
        busy_s = sel ? bus0.oBusy      : bus.oBusy;
        done_s = sel ? bus0.oDone      : bus.oDone;
        ovf_s  = sel ? bus0.oOverflow  : bus.oOverflow;
        prod_s = sel ? bus0.oProduct   : bus.oProduct;
        low_s  = sel ? bus0.oResultLow : bus.oResultLow;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic drive(input logic st, input logic [15:0] a, input logic [15:0] b, input logic s);
        if (sel) begin
            bus0.iStart = st; bus0.iData_A = a; bus0.iData_B = b; bus0.iSigned = s;
        end else begin
            bus.iStart = st; bus.iData_A = a; bus.iData_B = b; bus.iSigned = s;
        end
    endtask

    // Drive a start and step through the accept edge; afterwards we sit in cycle 1.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic s);
        drive(1'b1, a, b, s);
        tick();
        drive(1'b0, a, b, s);
    endtask

    // From cycle 'start', step until oDone; lat=-1 if the bound expires.
    task automatic wait_done(input int start, output int lat, output bit busy_ok);
        lat = start;
        busy_ok = 1'b1;
        while (!done_s && lat < 60) begin
            if (!busy_s) busy_ok = 1'b0;
            tick();
            lat++;
        end
        if (!done_s) lat = -1;
        else if (!busy_s) busy_ok = 1'b0;
    endtask

    task automatic run(input string tag, input logic [15:0] a, input logic [15:0] b, input logic s,
                       input int exp_lat, input logic [31:0] exp_p, input logic exp_o);
        int lat;
        bit bok;
        issue(a, b, s);
        wait_done(1, lat, bok);
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_prod"}, 64'(prod_s), 64'(exp_p));
        chk({tag, "_low"}, 64'(low_s), 64'(exp_p[15:0]));
        chk({tag, "_ovf"}, 64'(ovf_s), 64'(exp_o));
        chk({tag, "_busy"}, 64'(bok), 64'(1));
        tick();
        chk({tag, "_idle"}, 64'({busy_s, done_s}), 64'(0));
    endtask

    initial begin
        int lat;
        bit bok;
        int dones;
        bus.iStart = 0; bus.iSigned = 0; bus.iFlush = 0; bus.iData_A = 0; bus.iData_B = 0;
        bus0.iStart = 0; bus0.iSigned = 0; bus0.iFlush = 0; bus0.iData_A = 0; bus0.iData_B = 0;

        #12;
        chk("rst_busy", 64'(bus.oBusy), 64'(0));
        chk("rst_done", 64'(bus.oDone), 64'(0));
        chk("rst_prod", 64'(bus.oProduct), 64'(0));
        chk("rst_ovf",  64'(bus.oOverflow), 64'(0));
        @(negedge Clock);
        Reset = 1'b1;
        tick();

        run("u3x5",    16'h0003, 16'h0005, 1'b0, 18, 32'h0000000F, 1'b0);
        run("s-3x5",   16'hFFFD, 16'h0005, 1'b1, 18, 32'hFFFFFFF1, 1'b0);
        run("u-3x5",   16'hFFFD, 16'h0005, 1'b0, 18, 32'h0004FFF1, 1'b1);
        run("uFFFF2",  16'hFFFF, 16'hFFFF, 1'b0, 18, 32'hFFFE0001, 1'b1);
        run("s8000sq", 16'h8000, 16'h8000, 1'b1, 18, 32'h40000000, 1'b1);
        run("s8000x1", 16'h8000, 16'h0001, 1'b1, 18, 32'hFFFF8000, 1'b0);
        run("ez",      16'h1234, 16'h0000, 1'b0, 1,  32'h00000000, 1'b0);

        // Same zero operand on the EARLY_ZERO=0 instance, after a nonzero result
        sel = 1'b1;
        run("nz_pre",  16'h0003, 16'h0005, 1'b0, 18, 32'h0000000F, 1'b0);
        run("nz_zero", 16'h1234, 16'h0000, 1'b0, 18, 32'h00000000, 1'b0);
        sel = 1'b0;

        // Start while busy is ignored
        issue(16'd7, 16'd9, 1'b0);
        repeat (4) tick();
        drive(1'b1, 16'd2, 16'd2, 1'b0);
        tick();
        drive(1'b0, 16'd0, 16'd0, 1'b0);
        wait_done(6, lat, bok);
        chk("ign_lat", 64'(lat), 64'(18));
        chk("ign_prod", 64'(bus.oProduct), 64'h3F);
        // Hold start through DONE: accepted one cycle later
        drive(1'b1, 16'd2, 16'd3, 1'b0);
        tick();
        chk("hold_not_acc", 64'(bus.oBusy), 64'(0));
        tick();
        chk("hold_acc", 64'(bus.oBusy), 64'(1));
        drive(1'b0, 16'd0, 16'd0, 1'b0);
        wait_done(1, lat, bok);
        chk("hold_lat", 64'(lat), 64'(18));
        chk("hold_prod", 64'(bus.oProduct), 64'h6);
        tick();

        // Flush mid-operation
        issue(16'd100, 16'd100, 1'b0);
        repeat (7) tick();
        bus.iFlush = 1'b1;
        tick();
        bus.iFlush = 1'b0;
        chk("fl_busy", 64'(bus.oBusy), 64'(0));
        chk("fl_done", 64'(bus.oDone), 64'(0));
        chk("fl_prod", 64'(bus.oProduct), 64'h6);
        dones = 0;
        repeat (20) begin
            if (bus.oDone) dones++;
            tick();
        end
        chk("fl_nodone", 64'(dones), 64'(0));
        chk("fl_prod2", 64'(bus.oProduct), 64'h6);

        // Reset mid-operation
        issue(16'd100, 16'd100, 1'b0);
        repeat (7) tick();
        #2;
        Reset = 1'b0;
        #1;
        chk("ar_busy", 64'(bus.oBusy), 64'(0));
        chk("ar_done", 64'(bus.oDone), 64'(0));
        chk("ar_prod", 64'(bus.oProduct), 64'(0));
        chk("ar_ovf",  64'(bus.oOverflow), 64'(0));
        @(negedge Clock);
        Reset = 1'b1;
        tick();
        run("post_rst", 16'd100, 16'd100, 1'b0, 18, 32'h00002710, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running want=finished");
        $fatal(1);
    end
endmodule

// File: doc/seq_mul_unit.md
Name: seq_mul_unit

Overview:
- Parametrised, multi-cycle shift-add multiplier that replaces the fixed 4x4 array multiplier and the LUT multiplier in the ALU datapath.
- Supports signed and unsigned operands, selected per operation, at a configurable operand width.
- Uses a start/busy/done handshake so the ALU control can stall the instruction pointer while a product is computed.
- Returns the full double-width product and an overflow flag for the single-width result register.

Parameters:
WIDTH, 16, operand width in bits (legal range 4..32); product width is 2*WIDTH.
EARLY_ZERO, 1, when 1, a zero operand skips the CALC phase.

Ports:
Clock  input  1  system clock, all state changes on the rising edge.
Reset  input  1  asynchronous, active-low reset.
iStart  input  1  request a new multiplication; accepted only when oBusy=0.
iSigned  input  1  1 = two's-complement operands, 0 = unsigned; sampled with iStart.
iFlush  input  1  synchronous abort; returns the unit to IDLE.
iData_A  input  WIDTH  multiplicand, sampled when iStart is accepted.
iData_B  input  WIDTH  multiplier, sampled when iStart is accepted.
oBusy  output  1  high from the accept edge until the edge leaving DONE.
oDone  output  1  one-cycle pulse; the product is valid in this cycle.
oProduct  output  2*WIDTH  full product; holds its value until the next accepted start.
oResultLow  output  WIDTH  equals oProduct[WIDTH-1:0].
oOverflow  output  1  product does not fit in WIDTH bits.

Behaviour:
- Reset low (asynchronous): state=IDLE; oBusy=0, oDone=0, oProduct=0, oOverflow=0; all internal registers cleared.
- States: IDLE, CALC, SIGN, DONE.
- IDLE:
  - On iStart=1 at an edge, latch the operands and iSigned.
  - Load |A| and |B|: in signed mode take the two's-complement magnitude; the most-negative value has magnitude 2^(WIDTH-1), which fits unsigned.
  - Latch neg = iSigned & (A[msb] ^ B[msb]).
  - Clear the accumulator, set the bit counter to 0, go to CALC, oBusy=1.
  - If EARLY_ZERO=1 and A==0 or B==0, go directly to DONE with product 0.
- CALC:
  - Radix-2 step each cycle: if multiplier LSB is 1, add the multiplicand to the upper half of the accumulator.
  - Shift {carry, accumulator} right by 1; increment the counter.
  - After exactly WIDTH CALC cycles, go to SIGN.
- SIGN:
  - If neg, the product becomes its two's complement (2*WIDTH bits); otherwise unchanged.
  - Compute oOverflow:
    - unsigned: upper WIDTH bits != 0.
    - signed: upper WIDTH bits != replication of product[WIDTH-1].
  - Go to DONE.
- DONE:
  - oDone=1 for this single cycle; oProduct and oOverflow are registered and valid.
  - Go to IDLE; oBusy falls at this edge.
- Latency:
  - Normal case: oDone is high in cycle WIDTH+2 after the accept edge (accept edge = cycle 0).
  - Early-zero case: oDone is high in cycle 1.
- Back-to-back: iStart may be asserted in the DONE cycle, but is not accepted there because oBusy=1. It is accepted in the following IDLE cycle, so the minimum issue interval is WIDTH+3 cycles.
- iStart while oBusy=1 is ignored; the latched operands must not change.
- iFlush=1 in any state:
  - Go to IDLE next edge; oBusy=0, oDone=0.
  - oProduct and oOverflow keep their last completed value.
  - iFlush takes priority over iStart in the same cycle.
- Reset asserted mid-operation aborts immediately; no oDone is produced.
- oProduct updates only on the edge entering DONE.
- Arithmetic: internal sums use WIDTH+1 bits to keep the carry; no truncation before SIGN.

Test Plan:
- WIDTH=16, unsigned 3*5 -> oDone exactly 18 cycles after the accept edge; oProduct=0x0000000F, oResultLow=0x000F, oOverflow=0; oBusy high for cycles 1..18.
- Signed -3*5 (0xFFFD, 0x0005) -> oProduct=0xFFFFFFF1, oResultLow=0xFFF1, oOverflow=0. Same operands unsigned -> 0x0004FFF1, oOverflow=1.
- Unsigned 0xFFFF*0xFFFF -> 0xFFFE0001, oOverflow=1. Signed 0x8000*0x8000 -> 0x40000000, oOverflow=1. Signed 0x8000*0x0001 -> 0xFFFF8000, oOverflow=0.
- Early zero: 0x1234*0x0000 -> oDone at cycle 1, oProduct=0. With EARLY_ZERO=0 -> oDone at cycle 18, oProduct=0.
- Start 7*9, pulse iStart with 2*2 at cycle 5 -> the second request is ignored; the result is 0x3F at cycle 18. Holding iStart in DONE -> the request is accepted one cycle later.
- Start 100*100:
  - Assert iFlush at cycle 8 -> IDLE, no oDone, oProduct keeps its previous value.
  - Repeat, pulling Reset low at cycle 8 -> all outputs 0 immediately, asynchronously; a new start after release completes normally.
